cube_window_acc: RTL and testbench

Downstream consumer of the cubic-polynomial stage. Accumulates `WIN` consecutive valid 12-bit polynomial results (x³ + k) into a windowed sum. Presents each completed sum on a valid/ready output port. The upstream stage has no backpressure, so this block never stalls its input: a completed window that cannot be stored is dropped and flagged.

---
 rtl/cube_window_acc_if.sv | 25 ++
 rtl/cube_window_acc.sv | 98 +++++++++
 tb/tb_cube_window_acc.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cube_window_acc_if.sv
// Port bundle for cube_window_acc: sample input, clear, windowed-sum valid/ready output and status.
interface cube_window_acc_if #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned SUM_W = 16
);
    logic [IN_W-1:0]  cube_in;
    logic             cube_valid;
    logic             clr;
    logic [SUM_W-1:0] sum_out;
    logic             sum_valid;
    logic             sum_ready;
    logic             overflow;
    logic [7:0]       win_cnt;
    logic [3:0]       fill;

    modport master (
        output cube_in, cube_valid, clr, sum_ready,
        input  sum_out, sum_valid, overflow, win_cnt, fill
    );

    modport slave (
        input  cube_in, cube_valid, clr, sum_ready,
        output sum_out, sum_valid, overflow, win_cnt, fill
    );
endinterface

// File: rtl/cube_window_acc.sv
// Sums WIN valid samples per window and offers each total on a valid/ready port.
// The input never stalls: a window completing while the output is still occupied is dropped.
module cube_window_acc #(
    parameter int unsigned WIN   = 4,
    parameter int unsigned IN_W  = 12,
    parameter int unsigned SUM_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    cube_window_acc_if.slave  bus
);
    localparam logic [3:0] LastFill = 4'(WIN - 1);

    typedef enum logic {StEmpty, StFilling} acc_st_e;
    typedef enum logic {StOutEmpty, StOutFull} out_st_e;

    acc_st_e          acc_st_q, acc_st_d;
    out_st_e          out_st_q, out_st_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [3:0]       fill_q, fill_d;
    logic [SUM_W-1:0] sum_out_q, sum_out_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       win_cnt_q, win_cnt_d;

    logic [IN_W-1:0]  cube_in_w;
    logic [SUM_W-1:0] total;
    logic             xfer;

    assign cube_in_w = bus.cube_in;
    assign total     = acc_q + SUM_W'(cube_in_w);
    assign xfer      = (out_st_q == StOutFull) && bus.sum_ready;

    always_comb begin
        acc_st_d   = acc_st_q;
        out_st_d   = out_st_q;
        acc_d      = acc_q;
        fill_d     = fill_q;
        sum_out_d  = sum_out_q;
        overflow_d = overflow_q;
        win_cnt_d  = win_cnt_q;
        if (bus.clr) begin
            // Clear wins over samples and transfers; sum_out and win_cnt are kept.
            acc_st_d   = StEmpty;
            out_st_d   = StOutEmpty;
            acc_d      = '0;
            fill_d     = '0;
            overflow_d = 1'b0;
        end else begin
            if (xfer) begin
                win_cnt_d = win_cnt_q + 8'd1;
                out_st_d  = StOutEmpty;
            end
            if (bus.cube_valid) begin
                if (fill_q == LastFill) begin
                    acc_st_d = StEmpty;
                    acc_d    = '0;
                    fill_d   = '0;
                    if (out_st_q == StOutEmpty || xfer) begin
                        sum_out_d = total;
                        out_st_d  = StOutFull;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    acc_st_d = StFilling;
                    acc_d    = total;
                    fill_d   = fill_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_st_q   <= StEmpty;
            out_st_q   <= StOutEmpty;
            acc_q      <= '0;
            fill_q     <= '0;
            sum_out_q  <= '0;
            overflow_q <= 1'b0;
            win_cnt_q  <= '0;
        end else begin
            acc_st_q   <= acc_st_d;
            out_st_q   <= out_st_d;
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            sum_out_q  <= sum_out_d;
            overflow_q <= overflow_d;
            win_cnt_q  <= win_cnt_d;
        end
    end

    assign bus.sum_out   = sum_out_q;
    assign bus.sum_valid = (out_st_q == StOutFull);
    assign bus.overflow  = overflow_q;
    assign bus.win_cnt   = win_cnt_q;
    assign bus.fill      = fill_q;
endmodule

// File: tb/tb_cube_window_acc.sv
// Directed bench for cube_window_acc (WIN=4): windows, gaps, backpressure, clear and reset.
module tb_cube_window_acc;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    cube_window_acc_if #(.IN_W(12), .SUM_W(16)) bus ();

    cube_window_acc #(.WIN(4), .IN_W(12), .SUM_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int v);
        bus.cube_valid = 1'b1;
        bus.cube_in    = 12'(v);
        tick();
        bus.cube_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int so, input int sv, input int ov,
                           input int wc, input int fl);
        chk({tag, ".sum_out"}, 32'(bus.sum_out), 32'(so));
        chk({tag, ".sum_valid"}, 32'(bus.sum_valid), 32'(sv));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ov));
        chk({tag, ".win_cnt"}, 32'(bus.win_cnt), 32'(wc));
        chk({tag, ".fill"}, 32'(bus.fill), 32'(fl));
    endtask

    initial begin
        n_checks       = 0;
        n_fails        = 0;
        rst_n          = 1'b0;
        bus.cube_in    = '0;
        bus.cube_valid = 1'b0;
        bus.clr        = 1'b0;
        bus.sum_ready  = 1'b0;
        tick();
        tick();
        chk_out("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Basic window, ready held high
        bus.sum_ready = 1'b1;
        sample(8);
        chk("basic.fill1", 32'(bus.fill), 1);
        sample(27);
        sample(64);
        chk("basic.fill3", 32'(bus.fill), 3);
        sample(125);
        chk_out("basic.done", 224, 1, 0, 0, 0);
        tick();
        chk_out("basic.xfer", 224, 0, 0, 1, 0);

        // Max-value samples with idle gaps
        sample(3390);
        chk("gap.fill1", 32'(bus.fill), 1);
        tick();
        chk("gap.fill1_hold", 32'(bus.fill), 1);
        sample(3390);
        chk("gap.fill2", 32'(bus.fill), 2);
        tick();
        sample(3390);
        chk("gap.fill3", 32'(bus.fill), 3);
        tick();
        chk("gap.no_valid", 32'(bus.sum_valid), 0);
        sample(3390);
        chk_out("gap.done", 13560, 1, 0, 1, 0);
        tick();
        chk_out("gap.xfer", 13560, 0, 0, 2, 0);

        // Backpressure: second window dropped, overflow sticks
        bus.sum_ready = 1'b0;
        repeat (4) sample(1);
        chk_out("bp.first", 4, 1, 0, 2, 0);
        repeat (4) sample(2);
        chk_out("bp.drop", 4, 1, 1, 2, 0);
        bus.sum_ready = 1'b1;
        tick();
        chk_out("bp.xfer", 4, 0, 1, 3, 0);
        bus.sum_ready = 1'b0;
        bus.clr       = 1'b1;
        tick();
        bus.clr       = 1'b0;
        chk_out("bp.clr", 4, 0, 0, 3, 0);

        // Transfer and completion on the same edge
        repeat (4) sample(1);
        chk_out("b2b.held", 4, 1, 0, 3, 0);
        repeat (3) sample(3);
        chk_out("b2b.pending", 4, 1, 0, 3, 3);
        bus.sum_ready = 1'b1;
        sample(3);
        chk_out("b2b.swap", 12, 1, 0, 4, 0);
        bus.sum_ready = 1'b0;
        tick();
        chk_out("b2b.stable", 12, 1, 0, 4, 0);
        bus.sum_ready = 1'b1;
        tick();
        chk_out("b2b.xfer", 12, 0, 0, 5, 0);

        // Clear drops a coincident sample and the partial window
        sample(5);
        sample(5);
        chk("clr.fill2", 32'(bus.fill), 2);
        bus.clr = 1'b1;
        sample(7);
        bus.clr = 1'b0;
        chk("clr.fill0", 32'(bus.fill), 0);
        repeat (4) sample(10);
        chk_out("clr.window", 40, 1, 0, 5, 0);
        bus.sum_ready = 1'b0;
        repeat (4) sample(1);
        chk_out("clr.ovf", 40, 1, 1, 5, 0);
        bus.sum_ready = 1'b1;
        bus.clr       = 1'b1;
        tick();
        bus.clr       = 1'b0;
        bus.sum_ready = 1'b0;
        chk_out("clr.full", 40, 0, 0, 5, 0);

        // Asynchronous reset mid-window with output full
        repeat (4) sample(2);
        sample(9);
        sample(9);
        chk_out("rst.pre", 8, 1, 0, 5, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst.async", 0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        bus.sum_ready = 1'b1;
        repeat (4) sample(6);
        chk_out("rst.post", 24, 1, 0, 0, 0);
        tick();
        chk_out("rst.xfer", 24, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
